// File: rtl/mem_align_pkg.sv
// Shared encodings and helpers for the data-memory align/read-modify-write unit.
package mem_align_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_WR,
    ST_RSP
  } state_t;

  // Width in bits of the lane touched by a partial (byte/halfword) access.
  function automatic logic [4:0] lane_width(input logic [1:0] size);
    case (size)
      SZ_HALF: return 5'd16;
      default: return 5'd8;
    endcase
  endfunction

endpackage

// File: rtl/lane_merge_extract.sv
// Lane extraction with sign/zero extension for loads, and lane merge for partial stores.
module lane_merge_extract
  import mem_align_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int LANE_BITS = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0]    word,
  input  logic [LANE_BITS-1:0] lane,
  input  logic [1:0]           size,
  input  logic                 sgn,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    load_val,
  output logic [DATA_W-1:0]    merged
);

  logic [LANE_BITS-1:0] lane_eff;
  logic [LANE_BITS+2:0] bit_pos;
  logic [15:0]          low16;
  logic signed [7:0]    byte_s;
  logic signed [15:0]   half_s;
  logic [DATA_W-1:0]    field_mask;

  always_comb begin
    // Halfword accesses address lane pairs, so the low offset bit is dropped.
    lane_eff   = (size == SZ_HALF) ? {lane[LANE_BITS-1:1], 1'b0} : lane;
    bit_pos    = {lane_eff, 3'b000};
    low16      = 16'(word >> bit_pos);
    byte_s     = $signed(low16[7:0]);
    half_s     = $signed(low16);
    field_mask = ~({DATA_W{1'b1}} << lane_width(size));

    case (size)
      SZ_BYTE: load_val = sgn ? DATA_W'(byte_s) : DATA_W'(low16[7:0]);
      SZ_HALF: load_val = sgn ? DATA_W'(half_s) : DATA_W'(low16);
      default: load_val = word;
    endcase

    merged = (word & ~(field_mask << bit_pos)) | ((wdata & field_mask) << bit_pos);
  end

endmodule

// File: rtl/mem_align_rmw.sv
// Load/store access unit: aligned loads with extension, lane-accurate partial stores
// via read-modify-write, and error responses for misaligned or reserved-size requests.
module mem_align_rmw
  import mem_align_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WRITE,
  input  logic [1:0]        REQ_SIZE,
  input  logic              REQ_SIGNED,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_RD,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              MEM_RVALID,
  output logic              MEM_WR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              RSP_ERR
);

  localparam int LANE_BITS = $clog2(DATA_W / 8);

  state_t               state, state_nx;
  logic                 accept;
  logic                 bad_req;
  logic                 write_q;
  logic                 signed_q;
  logic [1:0]           size_q;
  logic [LANE_BITS-1:0] lane_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [DATA_W-1:0]    load_val;
  logic [DATA_W-1:0]    merged;

  assign accept = (state == ST_IDLE) && REQ_VALID;

  always_comb begin
    bad_req = 1'b0;
    case (REQ_SIZE)
      SZ_WORD: bad_req = |REQ_ADDR[LANE_BITS-1:0];
      SZ_HALF: bad_req = REQ_ADDR[0];
      SZ_BYTE: bad_req = 1'b0;
      default: bad_req = 1'b1;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (REQ_VALID) begin
          if (bad_req)                               state_nx = ST_RSP;
          else if (REQ_WRITE && REQ_SIZE == SZ_WORD) state_nx = ST_WR;
          else                                       state_nx = ST_RD;
        end
      end
      ST_RD:   state_nx = ST_WAIT;
      ST_WAIT: if (MEM_RVALID) state_nx = write_q ? ST_WR : ST_RSP;
      ST_WR:   state_nx = ST_RSP;
      ST_RSP:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Request capture: fields are only meaningful in the accept cycle.
  always_ff @(posedge CLK) begin
    if (accept) begin
      write_q  <= REQ_WRITE;
      size_q   <= REQ_SIZE;
      signed_q <= REQ_SIGNED;
      lane_q   <= REQ_ADDR[LANE_BITS-1:0];
      wdata_q  <= REQ_WDATA;
    end
  end

  lane_merge_extract #(
    .DATA_W    (DATA_W),
    .LANE_BITS (LANE_BITS)
  ) u_lane (
    .word     (MEM_RDATA),
    .lane     (lane_q),
    .size     (size_q),
    .sgn      (signed_q),
    .wdata    (wdata_q),
    .load_val (load_val),
    .merged   (merged)
  );

  // Outputs are registered from the next state so each strobe lines up with its state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      REQ_READY <= 1'b1;
      MEM_ADDR  <= '0;
      MEM_RD    <= 1'b0;
      MEM_WR    <= 1'b0;
      MEM_WDATA <= '0;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= '0;
      RSP_ERR   <= 1'b0;
    end else begin
      state     <= state_nx;
      REQ_READY <= (state_nx == ST_IDLE);
      MEM_RD    <= (state_nx == ST_RD);
      MEM_WR    <= (state_nx == ST_WR);
      RSP_VALID <= (state_nx == ST_RSP);
      RSP_ERR   <= (state == ST_IDLE) && (state_nx == ST_RSP);
      RSP_RDATA <= (state == ST_WAIT && state_nx == ST_RSP) ? load_val : '0;
      if (accept) MEM_ADDR <= {REQ_ADDR[ADDR_W-1:LANE_BITS], {LANE_BITS{1'b0}}};
      if (accept && REQ_WRITE) MEM_WDATA <= REQ_WDATA;
      else if (state == ST_WAIT && MEM_RVALID && write_q) MEM_WDATA <= merged;
    end
  end

endmodule

// File: tb/tb_mem_align_rmw.sv
// Randomised bench for mem_align_rmw against a byte-addressed memory model, plus a 64-bit instance.
module tb_mem_align_rmw;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, mem_addr, mem_rdata, mem_wdata, rsp_rdata;
  logic        mem_rd, mem_rvalid, mem_wr, rsp_valid, rsp_err;

  logic        req_valid64, req_ready64, req_write64, req_signed64;
  logic [1:0]  req_size64;
  logic [31:0] req_addr64, mem_addr64;
  logic [63:0] req_wdata64, mem_rdata64, mem_wdata64, rsp_rdata64;
  logic        mem_rd64, mem_rvalid64, mem_wr64, rsp_valid64, rsp_err64;

  mem_align_rmw #(.DATA_W(32), .ADDR_W(32)) u_dut (
    .CLK(clk), .RESET(rst), .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .REQ_WRITE(req_write), .REQ_SIZE(req_size), .REQ_SIGNED(req_signed),
    .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .MEM_ADDR(mem_addr), .MEM_RD(mem_rd),
    .MEM_RDATA(mem_rdata), .MEM_RVALID(mem_rvalid), .MEM_WR(mem_wr), .MEM_WDATA(mem_wdata),
    .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err)
  );

  mem_align_rmw #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
    .CLK(clk), .RESET(rst), .REQ_VALID(req_valid64), .REQ_READY(req_ready64),
    .REQ_WRITE(req_write64), .REQ_SIZE(req_size64), .REQ_SIGNED(req_signed64),
    .REQ_ADDR(req_addr64), .REQ_WDATA(req_wdata64), .MEM_ADDR(mem_addr64), .MEM_RD(mem_rd64),
    .MEM_RDATA(mem_rdata64), .MEM_RVALID(mem_rvalid64), .MEM_WR(mem_wr64),
    .MEM_WDATA(mem_wdata64), .RSP_VALID(rsp_valid64), .RSP_RDATA(rsp_rdata64),
    .RSP_ERR(rsp_err64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Byte-addressed reference memory; unwritten bytes read as a fixed address hash.
  logic [7:0] bmem [int unsigned];

  function automatic logic [7:0] getb(input int unsigned a);
    return bmem.exists(a) ? bmem[a] : 8'(a * 37 + 11);
  endfunction

  function automatic logic [31:0] getw(input int unsigned a);
    int unsigned b;
    b = a & ~32'h3;
    return {getb(b + 3), getb(b + 2), getb(b + 1), getb(b)};
  endfunction

  task automatic putw(input int unsigned a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) bmem[a + i] = 8'(w >> (8 * i));
  endtask

  // Expected transaction timeline, in cycles after the accept cycle (0); -1 = never.
  int          cyc = 0;
  int          e_rd = -1, e_wr = -1, e_rsp = -1;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic        e_err;
  bit          chk_en = 1'b0;
  logic [31:0] last_wdata, last_rdata;
  logic        last_err;

  always @(negedge clk) begin
    if (chk_en) begin
      if (cyc <= 0) begin
        chk("idle_ready", req_ready, 1'b1);
        chk("idle_strobes", {mem_rd, mem_wr, rsp_valid}, 3'b000);
      end else begin
        chk("busy_ready", req_ready, 1'b0);
        chk("mem_rd", mem_rd, cyc == e_rd);
        chk("mem_wr", mem_wr, cyc == e_wr);
        chk("rsp_valid", rsp_valid, cyc == e_rsp);
        if (cyc == e_rd || cyc == e_wr) chk("mem_addr", mem_addr, e_addr);
        if (cyc == e_wr) begin
          chk("mem_wdata", mem_wdata, e_wdata);
          last_wdata = mem_wdata;
        end
        if (cyc == e_rsp) begin
          chk("rsp_err", rsp_err, e_err);
          chk("rsp_rdata", rsp_rdata, e_rdata);
          last_rdata = rsp_rdata;
          last_err   = rsp_err;
        end
      end
    end
  end

  task automatic run(input bit w, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                     input logic [31:0] wd, input int n);
    int          nb;
    logic [31:0] rword, val;
    nb = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 1 : 0;
    if (nb == 0) e_err = 1'b1;
    else         e_err = (a % nb) != 0;
    e_addr  = a & ~32'h3;
    rword   = getw(e_addr);
    e_rd    = -1;
    e_wr    = -1;
    e_rdata = '0;
    e_wdata = '0;
    if (e_err) begin
      e_rsp = 1;
    end else if (!w) begin
      e_rd = 1;
      e_rsp = 3 + n;
      val = '0;
      for (int i = 0; i < nb; i++) val |= 32'(getb(a + i)) << (8 * i);
      if (sg && nb < 4 && val[8 * nb - 1]) val |= ~((32'd1 << (8 * nb)) - 1);
      e_rdata = val;
    end else begin
      if (nb == 4) begin
        e_wr = 1; e_rsp = 2;
      end else begin
        e_rd = 1; e_wr = 3 + n; e_rsp = 4 + n;
      end
      for (int i = 0; i < nb; i++) bmem[a + i] = 8'(wd >> (8 * i));
      e_wdata = getw(e_addr);
    end

    @(posedge clk); #1;
    cyc = 0;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd; mem_rvalid = 1'b0;
    @(posedge clk); #1;
    cyc = 1;
    req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
    req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    while (cyc <= e_rsp) begin
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (e_rd > 0 && cyc == 2 + n) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rword;
      end else if (e_rd > 0 && cyc == 1 && $urandom_range(0, 1) == 1) begin
        mem_rvalid = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    cyc = 0;
    mem_rvalid = 1'b0;
  endtask

  task automatic run64(input bit w, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                       input logic [63:0] wd, input logic [63:0] word,
                       output int rd_k, output int wr_k, output int rsp_k,
                       output logic [31:0] addr_o, output logic [63:0] wdat_o,
                       output logic [63:0] rdat_o, output logic err_o);
    rd_k = -1; wr_k = -1; rsp_k = -1; addr_o = '0; wdat_o = '0; rdat_o = '0; err_o = 1'b0;
    @(posedge clk); #1;
    req_valid64 = 1'b1; req_write64 = w; req_size64 = sz; req_signed64 = sg;
    req_addr64 = a; req_wdata64 = wd;
    @(posedge clk); #1;
    req_valid64 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      mem_rvalid64 = (k == 2);
      mem_rdata64  = (k == 2) ? word : {$urandom, $urandom};
      @(negedge clk);
      if (mem_rd64) begin rd_k = k; addr_o = mem_addr64; end
      if (mem_wr64) begin wr_k = k; wdat_o = mem_wdata64; end
      if (rsp_valid64) begin rsp_k = k; rdat_o = rsp_rdata64; err_o = rsp_err64; end
      @(posedge clk); #1;
    end
    mem_rvalid64 = 1'b0;
  endtask

  initial begin
    bit          w, sg;
    logic [1:0]  sz;
    logic [31:0] a, wd;
    int          n, r, rd_k, wr_k, rsp_k;
    logic [31:0] a64;
    logic [63:0] wdat64, rdat64;
    logic        err64;

    rst = 1'b1;
    req_valid = 0; req_write = 0; req_size = 0; req_signed = 0; req_addr = 0; req_wdata = 0;
    mem_rdata = 0; mem_rvalid = 0;
    req_valid64 = 0; req_write64 = 0; req_size64 = 0; req_signed64 = 0; req_addr64 = 0;
    req_wdata64 = 0; mem_rdata64 = 0; mem_rvalid64 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_strobes", {mem_rd, mem_wr, rsp_valid, rsp_err}, 4'b0000);
    chk("rst_data", {mem_addr, mem_wdata}, 64'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_ready64", req_ready64, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    putw(32'h10, 32'h11223344);
    run(1'b1, 2'b10, 1'b0, 32'h11, 32'h000000AA, 0);
    chk("sb_lit", last_wdata, 32'h1122AA44);
    chk("sb_lit_err", last_err, 1'b0);
    putw(32'h10, 32'h81223344);
    run(1'b0, 2'b10, 1'b1, 32'h13, 32'h0, 1);
    chk("lb_lit", last_rdata, 32'hFFFFFF81);
    run(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 0);
    chk("lbu_lit", last_rdata, 32'h00000081);
    run(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 2);
    chk("lhu_lit", last_rdata, 32'h00008122);
    putw(32'h10, 32'h11223344);
    run(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000BEEF, 0);
    chk("sh_lit", last_wdata, 32'hBEEF3344);
    run(1'b1, 2'b00, 1'b0, 32'h14, 32'hCAFEF00D, 0);
    chk("sw_lit", last_wdata, 32'hCAFEF00D);
    run(1'b1, 2'b01, 1'b0, 32'h11, 32'h1234, 0);
    chk("sh_mis_lit", {last_err, last_rdata}, {1'b1, 32'h0});
    run(1'b0, 2'b00, 1'b0, 32'h16, 32'h0, 0);
    chk("lw_mis_lit", {last_err, last_rdata}, {1'b1, 32'h0});
    run(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0);
    chk("rsvd_lit", {last_err, last_rdata}, {1'b1, 32'h0});

    // Reset while waiting for read data, then a stray late MEM_RVALID.
    chk_en = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b1; req_addr = 32'h13;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstw_ready", req_ready, 1'b1);
    chk("rstw_strobes", {mem_rd, mem_wr, rsp_valid}, 3'b000);
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h81818181;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rstw_quiet", {req_ready, mem_rd, mem_wr, rsp_valid}, 4'b1000);
    end
    chk_en = 1'b1;
    cyc = 0;
    run(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1);

    for (int t = 0; t < 250; t++) begin
      w  = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      a  = $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0)
        a = a & ~((sz == 2'b00) ? 32'h3 : (sz == 2'b01) ? 32'h1 : 32'h0);
      wd = $urandom;
      n  = $urandom_range(0, 3);
      run(w, sz, sg, a, wd, n);
    end

    run64(1'b1, 2'b10, 1'b0, 32'h0D, 64'h99, 64'h0011223344556677,
          rd_k, wr_k, rsp_k, a64, wdat64, rdat64, err64);
    chk("sb64_timing", {8'(rd_k), 8'(wr_k), 8'(rsp_k)}, {8'd1, 8'd3, 8'd4});
    chk("sb64_addr", a64, 32'h08);
    chk("sb64_wdata", wdat64, 64'h0011993344556677);
    chk("sb64_err", err64, 1'b0);
    run64(1'b0, 2'b10, 1'b1, 32'h0F, 64'h0, 64'h8011223344556677,
          rd_k, wr_k, rsp_k, a64, wdat64, rdat64, err64);
    chk("lb64_timing", {8'(rd_k), 8'(wr_k), 8'(rsp_k)}, {8'd1, 8'hFF, 8'd3});
    chk("lb64_rdata", rdat64, 64'hFFFFFFFFFFFFFF80);
    run64(1'b0, 2'b01, 1'b0, 32'h0A, 64'h0, 64'h8011223344556677,
          rd_k, wr_k, rsp_k, a64, wdat64, rdat64, err64);
    chk("lhu64_rdata", rdat64, 64'h0000000000004455);
    run64(1'b0, 2'b00, 1'b0, 32'h0C, 64'h0, 64'h8011223344556677,
          rd_k, wr_k, rsp_k, a64, wdat64, rdat64, err64);
    chk("lw64_mis", {8'(rd_k), 8'(rsp_k), 7'd0, err64}, {8'hFF, 8'd1, 8'd1});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
